// File: rtl/router_pkg.sv
// Shared types and header field helpers for the 1xN packet router.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DROP
  } fsm_state_e;

  // Header layout: {len, addr}, with addr in the low addr_w bits.
  function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int unsigned addr_w);
    return hdr & ((32'd1 << addr_w) - 32'd1);
  endfunction

  function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int unsigned addr_w,
                                          input int unsigned data_w);
    return (hdr >> addr_w) & ((32'd1 << (data_w - addr_w)) - 32'd1);
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Show-ahead output FIFO for one router port, with idle-read timeout flush.
module router_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 30
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic              wr_target_i,
  output logic              full_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              empty, full, push, pop, counting;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                 (wptr_q[PtrW-2:0] == rptr_q[PtrW-2:0]);
  assign push  = wr_en_i && !full;
  assign pop   = rd_en_i && !empty;
  // A write in the same cycle suppresses counting so a fresh byte is never flushed.
  assign counting = !empty && !rd_en_i && !wr_target_i && !wr_en_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = '0;
    if (push) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (counting) begin
      if (cnt_q == CntW'(TIMEOUT - 1)) begin
        rptr_d = wptr_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q[PtrW-2:0]] <= wr_data_i;
    end
  end

  assign full_o  = full;
  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rptr_q[PtrW-2:0]];

endmodule

// File: rtl/router_1xn_core.sv
// 1xN packet router: header/payload/parity framing FSM steering bytes into per-port FIFOs.
module router_1xn_core
  import router_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned N_PORTS    = 3,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 30
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      pkt_valid,
  output logic                      busy,
  output logic                      error,
  input  logic [N_PORTS-1:0]        read_enb,
  output logic [N_PORTS-1:0]        valid_out,
  output logic [N_PORTS*DATA_W-1:0] data_out
);

  localparam int unsigned ADDR_W = $clog2(N_PORTS);

  fsm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, hdr_a, wr_addr;
  logic [DATA_W-1:0] par_q, par_d, pbyte_q, pbyte_d;
  logic              error_q, error_d;
  logic              hdr_bad, hdr_full, cur_full, wr_req;
  logic [N_PORTS-1:0] full, wr_en, wr_target;
  logic [DATA_W-1:0] fifo_data [N_PORTS];

  always_comb begin
    hdr_a    = ADDR_W'(hdr_addr(32'(data_in), ADDR_W));
    hdr_bad  = (32'(hdr_a) >= N_PORTS);
    hdr_full = 1'b0;
    cur_full = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (hdr_a == ADDR_W'(i)) hdr_full = full[i];
      if (addr_q == ADDR_W'(i)) cur_full = full[i];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    par_d   = par_q;
    pbyte_d = pbyte_q;
    error_d = error_q;
    busy    = 1'b0;
    wr_req  = 1'b0;
    wr_addr = addr_q;
    case (state_q)
      IDLE: begin
        if (pkt_valid) begin
          if (hdr_bad) begin
            addr_d  = hdr_a;
            error_d = 1'b0;
            state_d = DROP;
          end else if (hdr_full) begin
            busy = 1'b1;
          end else begin
            wr_req  = 1'b1;
            wr_addr = hdr_a;
            addr_d  = hdr_a;
            par_d   = data_in;
            error_d = 1'b0;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (cur_full) begin
          busy = 1'b1;
        end else begin
          wr_req = 1'b1;
          if (pkt_valid) begin
            par_d = par_q ^ data_in;
          end else begin
            pbyte_d = data_in;
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        busy    = 1'b1;
        error_d = (par_q != pbyte_q);
        state_d = IDLE;
      end
      DROP: begin
        if (!pkt_valid) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      par_q   <= '0;
      pbyte_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      par_q   <= par_d;
      pbyte_q <= pbyte_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    assign wr_en[i]     = wr_req && (wr_addr == ADDR_W'(i));
    // Timeout is held off only while bytes are still streaming into this port.
    assign wr_target[i] = (state_q == LOAD) && (addr_q == ADDR_W'(i));

    router_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH),
      .TIMEOUT   (TIMEOUT)
    ) u_fifo (
      .clk_i      (clk),
      .rst_ni     (rst),
      .wr_en_i    (wr_en[i]),
      .wr_data_i  (data_in),
      .rd_en_i    (read_enb[i]),
      .wr_target_i(wr_target[i]),
      .full_o     (full[i]),
      .valid_o    (valid_out[i]),
      .data_o     (fifo_data[i])
    );

    assign data_out[i*DATA_W +: DATA_W] = fifo_data[i];
  end

endmodule

// File: tb/tb_router_1xn_core.sv
// Directed self-checking bench for router_1xn_core (DATA_W=8, N_PORTS=3, DEPTH=16, TIMEOUT=30).
module tb_router_1xn_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        pkt_valid;
  logic        busy;
  logic        error;
  logic [2:0]  read_enb;
  logic [2:0]  valid_out;
  logic [23:0] data_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] t1_bytes [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
  logic [7:0] t6_bytes [4] = '{8'h09, 8'hA5, 8'h5A, 8'hF6};

  always #5 clk = ~clk;

  router_1xn_core #(
    .DATA_W    (8),
    .N_PORTS   (3),
    .FIFO_DEPTH(16),
    .TIMEOUT   (30)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .pkt_valid(pkt_valid),
    .busy     (busy),
    .error    (error),
    .read_enb (read_enb),
    .valid_out(valid_out),
    .data_out (data_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a byte, hold it while busy (bounded), then let one edge accept it.
  task automatic send(input logic [7:0] b, input logic v, output int waited);
    data_in   = b;
    pkt_valid = v;
    waited    = 0;
    #1;
    while (busy === 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    if (waited >= 100) begin
      n_cmp++;
      n_err++;
      $error("FAIL send_stall observed=%0d expected=<100", waited);
    end
    step();
  endtask

  initial begin
    int w;
    int n;
    rst       = 1'b0;
    data_in   = '0;
    pkt_valid = 1'b0;
    read_enb  = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_dout", 32'(data_out), 32'h0);
    rst = 1'b1;
    step();

    // 1: good packet to port 1
    send(8'h0D, 1'b1, w);
    chk("t1_valid", 32'(valid_out), 32'h2);
    chk("t1_head", 32'(data_out[15:8]), 32'h0D);
    send(8'h11, 1'b1, w);
    send(8'h22, 1'b1, w);
    send(8'h33, 1'b1, w);
    send(8'h0D, 1'b0, w);
    chk("t1_check_busy", 32'(busy), 32'h1);
    step();
    chk("t1_error", 32'(error), 32'h0);
    read_enb = 3'b010;
    for (int k = 0; k < 5; k++) begin
      chk("t1_rd", 32'(data_out[15:8]), 32'(t1_bytes[k]));
      step();
    end
    read_enb = 3'b000;
    chk("t1_empty", 32'(valid_out), 32'h0);
    chk("t1_dout0", 32'(data_out), 32'h0);

    // 2: bad parity
    send(8'h0D, 1'b1, w);
    send(8'h11, 1'b1, w);
    send(8'h22, 1'b1, w);
    send(8'h33, 1'b1, w);
    send(8'h00, 1'b0, w);
    chk("t2_err_in_check", 32'(error), 32'h0);
    step();
    chk("t2_err_set", 32'(error), 32'h1);
    step();
    step();
    chk("t2_err_hold", 32'(error), 32'h1);
    read_enb = 3'b010;
    repeat (5) step();
    read_enb = 3'b000;
    chk("t2_drained", 32'(valid_out), 32'h0);

    // 3: invalid address 3 is dropped
    send(8'h07, 1'b1, w);
    chk("t3_wait_hdr", 32'(w), 32'h0);
    chk("t3_err_clear", 32'(error), 32'h0);
    chk("t3_busy_drop", 32'(busy), 32'h0);
    send(8'hAA, 1'b1, w);
    chk("t3_wait_pl", 32'(w), 32'h0);
    send(8'h5C, 1'b0, w);
    pkt_valid = 1'b0;
    chk("t3_wait_par", 32'(w), 32'h0);
    chk("t3_err_set", 32'(error), 32'h1);
    chk("t3_no_valid", 32'(valid_out), 32'h0);

    // 4: fill port 0 to 16 entries, then back-pressure and release
    send(8'h50, 1'b1, w);
    for (int k = 1; k <= 15; k++) send(8'(k), 1'b1, w);
    data_in   = 8'd16;
    pkt_valid = 1'b1;
    #1;
    chk("t4_full_busy", 32'(busy), 32'h1);
    chk("t4_valid", 32'(valid_out), 32'h1);
    step();
    chk("t4_busy_hold", 32'(busy), 32'h1);
    read_enb = 3'b001;
    chk("t4_no_bypass", 32'(busy), 32'h1);
    step();
    read_enb = 3'b000;
    chk("t4_pop_frees", 32'(busy), 32'h0);
    chk("t4_head_after_pop", 32'(data_out[7:0]), 32'h01);
    read_enb = 3'b001;
    for (int k = 16; k <= 20; k++) send(8'(k), 1'b1, w);
    send(8'h44, 1'b0, w);
    pkt_valid = 1'b0;
    step();
    chk("t4_error", 32'(error), 32'h0);
    n = 0;
    while (valid_out[0] === 1'b1 && n < 50) begin
      step();
      n++;
    end
    read_enb = 3'b000;
    chk("t4_drained", 32'(valid_out), 32'h0);

    // 5: unread port 2 is flushed 31 edges after its header write
    send(8'h02, 1'b1, w);
    chk("t5_valid", 32'(valid_out), 32'h4);
    send(8'h02, 1'b0, w);
    pkt_valid = 1'b0;
    repeat (29) step();
    chk("t5_before_flush", 32'(valid_out[2]), 32'h1);
    step();
    chk("t5_flushed", 32'(valid_out), 32'h0);
    chk("t5_dout0", 32'(data_out[23:16]), 32'h0);

    // 6: reset mid-payload, then a clean packet to port 1
    send(8'h0D, 1'b1, w);
    send(8'h11, 1'b1, w);
    data_in   = 8'h22;
    pkt_valid = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_error", 32'(error), 32'h0);
    chk("t6_valid", 32'(valid_out), 32'h0);
    chk("t6_dout", 32'(data_out), 32'h0);
    pkt_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    send(8'h09, 1'b1, w);
    send(8'hA5, 1'b1, w);
    send(8'h5A, 1'b1, w);
    send(8'hF6, 1'b0, w);
    pkt_valid = 1'b0;
    step();
    chk("t6_pkt_error", 32'(error), 32'h0);
    read_enb = 3'b010;
    for (int k = 0; k < 4; k++) begin
      chk("t6_rd", 32'(data_out[15:8]), 32'(t6_bytes[k]));
      step();
    end
    read_enb = 3'b000;
    chk("t6_empty", 32'(valid_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
